// File: rtl/marquee_sequencer.sv
// Marquee sequencer: produces the 3-bit position select for the rotating
// seven-segment marquee. It supports free-running advance at a selectable
// rate, pause/resume without phase loss, single-step and direction control.
module marquee_sequencer #(
  parameter int DIV_W    = 24,
  parameter int BASE_DIV = 12500000
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       DIR,
  input  logic [1:0] SPEED,
  output logic [2:0] SEL,
  output logic       TICK,
  output logic       WRAP,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  // One extra bit holds BASE_DIV == 2^DIV_W exactly. The subtraction then
  // wraps it back to the all-ones terminal count once it is truncated.
  localparam logic [DIV_W:0] BASE_W = (DIV_W+1)'(BASE_DIV);
  localparam logic [DIV_W:0] ONE_W  = (DIV_W+1)'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step_q;

  logic [DIV_W-1:0] tc;
  logic             step_edge;
  logic [2:0]       sel_next;
  logic             wraps;

  // Terminal count for the selected rate. Each SPEED step halves the period.
  assign tc = DIV_W'((BASE_W >> SPEED) - ONE_W);

  assign step_edge = STEP & ~step_q;
  assign sel_next  = DIR ? (sel_q - 3'd1) : (sel_q + 3'd1);
  assign wraps     = DIR ? (sel_q == 3'd0) : (sel_q == 3'd7);

  // Next-state logic. It decides the mode transition and whether this edge
  // advances the position.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a value
    // unassigned. An unassigned path would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (RUN) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          sel_d   = sel_next;
          tick_d  = 1'b1;
          wrap_d  = wraps;
          state_d = S_PAUSE;
        end
      end

      S_RUN: begin
        if (!RUN) begin
          // The count freezes where it is, so a later resume keeps the phase.
          state_d = S_PAUSE;
        end else if (cnt_q >= tc) begin
          // Use >= rather than ==, so that a SPEED increase in mid-count
          // advances at once and the counter never overflows.
          cnt_d  = '0;
          sel_d  = sel_next;
          tick_d = 1'b1;
          wrap_d = wraps;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_PAUSE: begin
        if (RUN) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          sel_d  = sel_next;
          tick_d = 1'b1;
          wrap_d = wraps;
        end
      end

      default: begin
        // Unreachable encoding. Recover to IDLE and keep the position.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous clear. The step history is loaded
  // during clear, so a key held through reset does not fire a step.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values sampled before the edge.
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      step_q  <= STEP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      step_q  <= STEP;
    end
  end

  assign SEL   = sel_q;
  assign TICK  = tick_q;
  assign WRAP  = wrap_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_marquee_sequencer.sv
// Testbench for marquee_sequencer. A behavioural model is compared against
// the DUT on every cycle after the first clear. Directed scenarios add
// hand-computed literal expectations.
module tb_marquee_sequencer;

  localparam int DIV_W    = 24;
  localparam int BASE_DIV = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       CLK;
  logic       CLR;
  logic       RUN;
  logic       STEP;
  logic       DIR;
  logic [1:0] SPEED;
  logic [2:0] SEL;
  logic       TICK;
  logic       WRAP;
  logic [1:0] STATE;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the marquee, kept as plain integers.
  int m_sel   = 0;
  int m_count = 0;
  int m_mode  = M_IDLE;
  bit m_tick  = 0;
  bit m_wrap  = 0;
  bit m_step_prev = 0;
  bit m_valid = 0;
  bit m_edge;
  int m_tc;

  // Observed tick history, used by the directed checks.
  int tick_count = 0;
  int wrap_count = 0;
  int tick_sel_q[$];
  int tick_wrap_q[$];

  marquee_sequencer #(.DIV_W(DIV_W), .BASE_DIV(BASE_DIV)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .RUN   (RUN),
    .STEP  (STEP),
    .DIR   (DIR),
    .SPEED (SPEED),
    .SEL   (SEL),
    .TICK  (TICK),
    .WRAP  (WRAP),
    .STATE (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_advance();
    m_wrap = DIR ? (m_sel == 0) : (m_sel == 7);
    m_sel  = DIR ? (m_sel + 7) % 8 : (m_sel + 1) % 8;
    m_tick = 1'b1;
  endfunction

  // Model update on each active edge, using the inputs held stable there.
  always @(posedge CLK) begin
    m_edge = STEP && !m_step_prev;
    m_tc   = (BASE_DIV >> SPEED) - 1;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (CLR) begin
      m_sel = 0; m_count = 0; m_mode = M_IDLE; m_step_prev = STEP; m_valid = 1'b1;
    end else begin
      m_step_prev = STEP;
      if (m_mode == M_RUN) begin
        if (!RUN) m_mode = M_PAUSE;
        else if (m_count >= m_tc) begin m_count = 0; model_advance(); end
        else m_count++;
      end else begin
        if (m_mode == M_IDLE) m_count = 0;
        if (RUN) m_mode = M_RUN;
        else if (m_edge) begin model_advance(); m_mode = M_PAUSE; end
      end
    end
  end

  // Compare the DUT with the model on the inactive edge, and log ticks.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("sel",   32'(SEL),   32'(m_sel));
      check("tick",  32'(TICK),  32'(m_tick));
      check("wrap",  32'(WRAP),  32'(m_wrap));
      check("state", 32'(STATE), 32'(m_mode));
    end
    if (TICK === 1'b1) begin
      tick_count++;
      tick_sel_q.push_back(int'(SEL));
      tick_wrap_q.push_back(int'(WRAP));
    end
    if (WRAP === 1'b1) wrap_count++;
  end

  // Advance n cycles. Inputs change just after the inactive edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    tick_count = 0;
    wrap_count = 0;
    tick_sel_q.delete();
    tick_wrap_q.delete();
  endtask

  task automatic wait_ticks(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tick_sel_q.size() >= n) break;
      cyc(1);
    end
    check("wait_ticks", 32'(tick_sel_q.size()), 32'(n));
  endtask

  task automatic pulse_step();
    STEP = 1'b1; cyc(1);
    STEP = 1'b0; cyc(1);
  endtask

  initial begin
    int widths [3] = '{1, 5, 40};
    CLR = 1'b1; RUN = 1'b0; STEP = 1'b0; DIR = 1'b0; SPEED = 2'd0;
    cyc(2);
    check("reset_sel",   32'(SEL),   0);
    check("reset_state", 32'(STATE), 0);
    check("reset_tick",  32'(TICK),  0);
    check("reset_wrap",  32'(WRAP),  0);

    // Free run at SPEED=0 (TC=15). The first advance comes 16 edges after entry.
    CLR = 1'b0; RUN = 1'b1; clear_log();
    cyc(16);
    check("run_pre_first_tick", 32'(TICK), 0);
    check("run_pre_first_sel",  32'(SEL),  0);
    cyc(1);
    check("run_first_tick", 32'(TICK), 1);
    check("run_first_sel",  32'(SEL),  1);
    cyc(53);
    check("run70_sel",   32'(SEL), 4);
    check("run70_ticks", 32'(tick_count), 4);
    check("run70_wraps", 32'(wrap_count), 0);

    // Step up to position 6 from a clean reset, then run fast (TC=1) across the wrap.
    RUN = 1'b0; CLR = 1'b1; cyc(1);
    CLR = 1'b0;
    repeat (6) pulse_step();
    check("step_to6_sel",   32'(SEL),   6);
    check("step_to6_state", 32'(STATE), M_PAUSE);
    clear_log();
    SPEED = 2'd3; RUN = 1'b1;
    wait_ticks(3, 20);
    RUN = 1'b0;
    if (tick_sel_q.size() >= 3) begin
      check("up_sel0",  32'(tick_sel_q[0]),  7);
      check("up_wrap0", 32'(tick_wrap_q[0]), 0);
      check("up_sel1",  32'(tick_sel_q[1]),  0);
      check("up_wrap1", 32'(tick_wrap_q[1]), 1);
      check("up_sel2",  32'(tick_sel_q[2]),  1);
      check("up_wrap2", 32'(tick_wrap_q[2]), 0);
    end
    cyc(1);
    clear_log();
    DIR = 1'b1; RUN = 1'b1;
    wait_ticks(2, 20);
    RUN = 1'b0;
    if (tick_sel_q.size() >= 2) begin
      check("dn_sel0",  32'(tick_sel_q[0]),  0);
      check("dn_wrap0", 32'(tick_wrap_q[0]), 0);
      check("dn_sel1",  32'(tick_sel_q[1]),  7);
      check("dn_wrap1", 32'(tick_wrap_q[1]), 1);
    end

    // Pause at CNT=9, hold, resume. The next tick comes 7 edges after resume.
    DIR = 1'b0; SPEED = 2'd0;
    cyc(1);
    RUN = 1'b1; cyc(10);
    check("pr_state_run", 32'(STATE), M_RUN);
    RUN = 1'b0; cyc(1);
    check("pr_state_pause", 32'(STATE), M_PAUSE);
    clear_log();
    cyc(19);
    check("pr_sel_held", 32'(SEL), 7);
    check("pr_no_ticks", 32'(tick_count), 0);
    RUN = 1'b1; cyc(1);
    check("pr_state_resumed", 32'(STATE), M_RUN);
    cyc(6);
    check("pr_tick_not_yet", 32'(TICK), 0);
    cyc(1);
    check("pr_tick", 32'(TICK), 1);
    check("pr_sel",  32'(SEL),  0);
    check("pr_wrap", 32'(WRAP), 1);

    // Single steps of varied width in PAUSE. Each gives exactly one advance.
    RUN = 1'b0; cyc(1);
    clear_log();
    foreach (widths[i]) begin
      STEP = 1'b1; cyc(widths[i]);
      STEP = 1'b0; cyc(3);
    end
    check("ss_ticks", 32'(tick_count), 3);
    check("ss_sel",   32'(SEL), 3);
    check("ss_state", 32'(STATE), M_PAUSE);

    // STEP activity while running gives no extra advances.
    clear_log();
    RUN = 1'b1;
    repeat (5) pulse_step();
    RUN = 1'b0; cyc(1);
    check("run_step_ticks", 32'(tick_count), 0);
    check("run_step_sel",   32'(SEL), 3);

    // Reach SEL=5, CNT=12 with STEP held. RUN wins over the step edge.
    repeat (2) pulse_step();
    RUN = 1'b1; STEP = 1'b1; cyc(4);
    check("pre_clr_sel",   32'(SEL), 5);
    check("pre_clr_state", 32'(STATE), M_RUN);
    CLR = 1'b1; cyc(1);
    check("clr_sel",   32'(SEL), 0);
    check("clr_state", 32'(STATE), M_IDLE);
    check("clr_tick",  32'(TICK), 0);
    CLR = 1'b0; RUN = 1'b0; cyc(5);
    check("post_clr_sel",   32'(SEL), 0);
    check("post_clr_state", 32'(STATE), M_IDLE);
    STEP = 1'b0; cyc(2);
    STEP = 1'b1; cyc(1);
    check("restep_sel",   32'(SEL), 1);
    check("restep_state", 32'(STATE), M_PAUSE);
    check("restep_tick",  32'(TICK), 1);
    STEP = 1'b0;

    // Change SPEED 0 -> 2 at CNT=10. The advance is immediate, then every 4 cycles.
    clear_log();
    SPEED = 2'd0; RUN = 1'b1; cyc(11);
    check("sc_state",    32'(STATE), M_RUN);
    check("sc_no_ticks", 32'(tick_count), 0);
    SPEED = 2'd2; cyc(1);
    check("sc_tick", 32'(TICK), 1);
    check("sc_sel",  32'(SEL), 2);
    clear_log();
    cyc(16);
    check("sc_ticks16", 32'(tick_count), 4);
    check("sc_sel16",   32'(SEL), 6);

    RUN = 1'b0; cyc(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
